// File: rtl/insn_prefetch_pkg.sv
// Shared instruction-fetch definitions.
// Holds the instruction and program-counter widths, the default reset PC and
// the FIFO entry layout so that fetch, execute and redirect logic agree.
package insn_prefetch_pkg;

   localparam int LEN_INSN = 32;
   localparam int LEN_PC   = 16;

   localparam logic [LEN_PC-1:0] DEFAULT_RESET_PC = '0;

   // One buffered fetch result: the instruction word and the word address it
   // was read from.
   typedef struct packed {
      logic [LEN_PC-1:0]   pc;
      logic [LEN_INSN-1:0] insn;
   } fetch_entry_t;

endpackage

// File: rtl/insn_fifo.sv
// insn_fifo: parameterised synchronous FIFO.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   flush_i         empties the FIFO; overrides push and pop this cycle
//   push_i, data_i  write request and data (ignored when full, unless popping)
//   pop_i           read request (ignored when empty)
//   head_o          entry at the read pointer (stale when count_o is 0)
//   count_o         number of stored entries, 0..DEPTH
module insn_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 48
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush_i,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [WIDTH-1:0]           data_i,
   output logic [WIDTH-1:0]           head_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];

   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push;
   logic          do_pop;

   always_comb begin
      do_pop   = pop_i && (count_q != '0);
      // A full FIFO can still accept a write when a pop frees a slot this cycle.
      do_push  = push_i && ((count_q != CW'(DEPTH)) || do_pop);
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         // DEPTH is a power of two, so pointers wrap naturally.
         if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries data only and needs no reset.
   always_ff @(posedge clk) begin
      if (do_push && !flush_i && !rst) begin
         mem[wr_ptr_q] <= data_i;
      end
   end

   assign head_o  = mem[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/insn_prefetch_buffer.sv
// insn_prefetch_buffer: instruction prefetch stage.
// Owns the PC, issues one read per cycle to a synchronous instruction ROM
// (data returns one cycle after the strobe) and buffers results in a FIFO so
// the decoder can stall without losing reads already in flight. A redirect
// flushes the buffer and restarts fetch at a new PC.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   valid_i                  fetch enable (stops issue only)
//   stall_o                  buffered plus in-flight entries fill DEPTH slots
//   imem_en_o, imem_addr_o   ROM read strobe and word address
//   imem_data_i              ROM read data, one cycle after imem_en_o
//   redirect_i, redirect_pc_i taken branch: flush and restart at redirect_pc_i
//   valid_o, insn_o, pc_o    head instruction and its address
//   stall_i                  decoder cannot accept the head this cycle
module insn_prefetch_buffer
   import insn_prefetch_pkg::*;
#(
   parameter int                DEPTH    = 4,
   parameter logic [LEN_PC-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                valid_i,
   output logic                stall_o,
   output logic                imem_en_o,
   output logic [LEN_PC-1:0]   imem_addr_o,
   input  logic [LEN_INSN-1:0] imem_data_i,
   input  logic                redirect_i,
   input  logic [LEN_PC-1:0]   redirect_pc_i,
   output logic                valid_o,
   input  logic                stall_i,
   output logic [LEN_INSN-1:0] insn_o,
   output logic [LEN_PC-1:0]   pc_o
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [LEN_PC-1:0] pc_q, pc_d;
   logic              inflight_q, inflight_d;
   logic [LEN_PC-1:0] inflight_pc_q, inflight_pc_d;
   logic              kill_q, kill_d;

   logic [CW-1:0]     count;
   logic [CW:0]       occupancy;
   logic              issue;
   logic              push;
   logic              pop;
   fetch_entry_t      push_entry;
   fetch_entry_t      head_entry;

   // Slots already committed: buffered entries plus the read still in flight.
   assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight_q};

   always_comb begin
      issue         = !rst && valid_i && !redirect_i && (occupancy < (CW+1)'(DEPTH));
      pc_d          = pc_q;
      inflight_d    = issue;
      inflight_pc_d = inflight_pc_q;
      kill_d        = 1'b0;
      if (issue) begin
         pc_d          = pc_q + LEN_PC'(1);
         inflight_pc_d = pc_q;
      end
      if (redirect_i) begin
         pc_d   = redirect_pc_i;
         kill_d = inflight_q;
      end
   end

   // A response is dropped if it belongs to a stream that was redirected away.
   assign push = inflight_q && !kill_q && !redirect_i;
   assign pop  = valid_o && !stall_i && !redirect_i;

   always_comb begin
      push_entry      = '0;
      push_entry.pc   = inflight_pc_q;
      push_entry.insn = imem_data_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q       <= RESET_PC;
         inflight_q <= 1'b0;
         kill_q     <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         inflight_q <= inflight_d;
         kill_q     <= kill_d;
      end
   end

   always_ff @(posedge clk) begin
      inflight_pc_q <= inflight_pc_d;
   end

   insn_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(fetch_entry_t))
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush_i (redirect_i),
      .push_i  (push),
      .pop_i   (pop),
      .data_i  (push_entry),
      .head_o  (head_entry),
      .count_o (count)
   );

   assign imem_en_o   = issue;
   assign imem_addr_o = pc_q;
   assign valid_o     = !rst && (count != '0);
   assign stall_o     = !rst && (occupancy >= (CW+1)'(DEPTH));
   assign insn_o      = head_entry.insn;
   assign pc_o        = head_entry.pc;

endmodule
